// File: rtl/bcd_pkg.sv
// Shared constants for the binary-to-BCD converter: digit count, saturation
// limit and FSM state encodings.
package bcd_pkg;

  localparam int          BCD_DIGITS = 8;
  localparam logic [26:0] BCD_MAX    = 27'd99_999_999;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-packed-BCD converter, one shift-and-add-3 step per
// clock; results land in a held output register only on completion.
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int INPUT_WIDTH = 27
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start_i,
  input  logic [INPUT_WIDTH-1:0] Binary_i,
  output logic [31:0]            Data_o,
  output logic                   Overflow_o,
  output logic                   Busy_o,
  output logic                   Done_o
);

  localparam int CNT_W  = $clog2(INPUT_WIDTH);
  localparam bit SAT_EN = (INPUT_WIDTH == 27);

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0] operand_q, operand_d;
  logic [31:0]            scratch_q, scratch_d;
  logic [31:0]            data_q, data_d;
  logic                   pend_ovf_q, pend_ovf_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [31:0] adj;
  logic [26:0] bin_ext;
  logic        sat;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  // Only a full 27-bit input can exceed eight decimal digits.
  assign bin_ext = 27'(Binary_i);
  assign sat     = SAT_EN && (bin_ext > BCD_MAX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    operand_d  = operand_q;
    scratch_d  = scratch_q;
    data_d     = data_q;
    pend_ovf_d = pend_ovf_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          operand_d  = sat ? INPUT_WIDTH'(BCD_MAX) : Binary_i;
          pend_ovf_d = sat;
          scratch_d  = '0;
          cnt_d      = CNT_W'(INPUT_WIDTH - 1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[30:0], operand_q[INPUT_WIDTH-1]};
        operand_d = {operand_q[INPUT_WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        data_d  = scratch_q;
        ovf_d   = pend_ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      operand_q  <= '0;
      scratch_q  <= '0;
      data_q     <= '0;
      pend_ovf_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      operand_q  <= operand_d;
      scratch_q  <= scratch_d;
      data_q     <= data_d;
      pend_ovf_q <= pend_ovf_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign Data_o     = data_q;
  assign Overflow_o = ovf_q;
  assign Busy_o     = (state_q != IDLE);
  assign Done_o     = done_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: accepted starts push decimal-arithmetic
// expectations; a negedge monitor pops them on Done_o and checks held outputs.
module tb_bcd_converter;

  localparam int W = 27;
  localparam longint unsigned MAXV = 64'd99_999_999;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } exp_t;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Start_i = 1'b0;
  logic [W-1:0] Binary_i = '0;
  logic [31:0]  Data_o;
  logic         Overflow_o;
  logic         Busy_o;
  logic         Done_o;

  bcd_converter #(.INPUT_WIDTH(W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start_i    (Start_i),
    .Binary_i   (Binary_i),
    .Data_o     (Data_o),
    .Overflow_o (Overflow_o),
    .Busy_o     (Busy_o),
    .Done_o     (Done_o)
  );

  initial forever #5 Clock = ~Clock;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   mcnt = 0;
  bit   exp_done = 1'b0;
  bit   mon_en = 1'b0;
  exp_t hold = '0;
  int   cyc = 0;

  function automatic exp_t ref_conv(input longint unsigned v);
    exp_t r;
    longint unsigned s;
    s = (v > MAXV) ? MAXV : v;
    for (int i = 0; i < 8; i++) begin
      r.d[4*i +: 4] = 4'(s % 10);
      s = s / 10;
    end
    r.o = (v > MAXV);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference timing: busy for W+1 cycles after an accepted start, done at the last.
  always @(posedge Clock) begin
    cyc++;
    if (Reset) begin
      q.delete();
      mcnt     = 0;
      exp_done = 1'b0;
      hold     = '0;
      mon_en   = 1'b1;
    end else begin
      exp_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) exp_done = 1'b1;
      end else if (Start_i) begin
        q.push_back(ref_conv(64'(Binary_i)));
        mcnt = W + 1;
      end
    end
  end

  always @(negedge Clock) begin
    exp_t e;
    if (mon_en) begin
      check("busy", 32'(Busy_o), 32'(mcnt != 0));
      check("done", 32'(Done_o), 32'(exp_done));
      if (Done_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got Done_o=1 expected no pending result");
        end else begin
          e = q.pop_front();
          check("data", Data_o, e.d);
          check("overflow", 32'(Overflow_o), 32'(e.o));
          hold = e;
        end
      end else begin
        check("data_hold", Data_o, hold.d);
        check("ovf_hold", 32'(Overflow_o), 32'(hold.o));
      end
    end
  end

  task automatic start(input logic [W-1:0] v);
    Start_i  = 1'b1;
    Binary_i = v;
    @(negedge Clock);
    Start_i  = 1'b0;
    Binary_i = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done_o && n < 60) begin
      @(negedge Clock);
      n++;
    end
    if (!Done_o) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no Done_o expected within 60 cycles");
    end
  endtask

  initial begin
    int last_done;
    logic [W-1:0] v;

    @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    start(W'(0));                wait_done();
    start(W'(12_345_678));       wait_done();
    start(W'(99_999_999));       wait_done();
    start(W'(100_000_000));      wait_done();
    start(W'(134_217_727));      wait_done();

    // Starts while busy must be ignored.
    start(W'(42));               wait_done();
    start(W'(7));
    repeat (5) @(negedge Clock);
    Start_i = 1'b1; Binary_i = W'(555);
    repeat (2) @(negedge Clock);
    Start_i = 1'b0;
    wait_done();
    repeat (3) @(negedge Clock);

    // Reset at edge 10 of a conversion discards it.
    start(W'(87_654_321));
    repeat (9) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    start(W'(305));              wait_done();
    @(negedge Clock);

    // Reset and start together: reset wins.
    Reset = 1'b1; Start_i = 1'b1; Binary_i = W'(9);
    @(negedge Clock);
    Reset = 1'b0; Start_i = 1'b0;
    repeat (2) @(negedge Clock);

    // Back-to-back with Start_i held high.
    Binary_i = W'(1);
    Start_i  = 1'b1;
    last_done = 0;
    for (int k = 0; k < 6; k++) begin
      wait_done();
      if (k > 0) check("b2b_spacing", 32'(cyc - last_done), 32'(W + 2));
      last_done = cyc;
      Binary_i = (k % 2 == 0) ? W'(10) : W'(1);
      if (k == 5) Start_i = 1'b0;
      @(negedge Clock);
    end

    // Random operands, including values near the saturation limit.
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0:       v = W'($urandom_range(99_999_990, 100_000_010));
        1:       v = W'($urandom_range(0, 999));
        default: v = W'($urandom);
      endcase
      start(v);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) @(negedge Clock);
        Start_i = 1'b1; Binary_i = W'($urandom);
        @(negedge Clock);
        Start_i = 1'b0;
      end
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge Clock);
    end

    repeat (3) @(negedge Clock);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_converter.md
# bcd_converter

Sequential binary-to-BCD converter feeding the 32-bit packed-BCD data input of the multiplexed 8-digit display driver. It accepts an unsigned binary value on a start strobe and runs one shift-and-add-3 (double-dabble) step per clock. When finished it presents eight BCD digits on a held output register, so the display never sees partial results. Values above 99 999 999 saturate and raise an overflow flag.

## Interface
- `INPUT_WIDTH`, default 27: width of `Binary_i`; legal range 4..27 (27 bits covers 99 999 999).
- `Clock`  in  1: system clock; all logic on its rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Start_i`  in  1: request a conversion of `Binary_i`; sampled only in IDLE.
- `Binary_i`  in  INPUT_WIDTH: unsigned value, captured on the accepting edge.
- `Data_o`  out  32: packed BCD, digit 7 in [31:28], digit 0 in [3:0]; updated only on completion.
- `Overflow_o`  out  1: high if the last completed conversion saturated; updated with `Data_o`.
- `Busy_o`  out  1: high while a conversion is in progress (state ≠ IDLE).
- `Done_o`  out  1: one-cycle registered strobe; new `Data_o` is valid in that cycle.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On `Start_i`=1, capture the operand.
  - If `Binary_i` > 99 999 999, load 99 999 999 and set the pending-overflow bit; otherwise load `Binary_i` and clear it.
  - Clear the 32-bit BCD scratch register.
  - Load the bit counter with INPUT_WIDTH−1 and go to SHIFT.
- SHIFT, each cycle:
  - Every scratch digit ≥ 5 gets +3 (mod 16, per nibble, no carry between nibbles).
  - Then the concatenation {scratch, operand} shifts left by 1.
  - The counter decrements. When the counter is 0 at this edge, go to DONE.
- DONE:
  - `Data_o` ← scratch, `Overflow_o` ← pending-overflow, `Done_o` ← 1.
  - Go to IDLE.
- `Done_o` is cleared on every other edge.
- Saturation applies only when INPUT_WIDTH = 27; narrower inputs cannot overflow, and `Overflow_o` stays 0.
- `Start_i` in SHIFT or DONE is ignored, not queued.
- `Binary_i` may change after the accepting edge without effect.
- `Data_o` and `Overflow_o` hold their last completed values indefinitely, including while Busy.
- Reset, at any time including mid-conversion, drives all of the following to 0 and puts the FSM in IDLE; the partial result is discarded:
  - `Data_o` (0x0000_0000, which the display shows as "0"), `Overflow_o`, `Busy_o`, `Done_o`
  - scratch register, operand register, counter
- `Reset` and `Start_i` high on the same edge: reset wins and the conversion is not started.

## Timing
- Edge 0 samples `Start_i`=1 in IDLE. After edge 0, `Busy_o`=1.
- Edges 1..INPUT_WIDTH perform the shifts. After edge INPUT_WIDTH, state = DONE.
- Edge INPUT_WIDTH+1 updates `Data_o`/`Overflow_o`, sets `Done_o`=1, state = IDLE, `Busy_o`=0.
- Edge INPUT_WIDTH+2 clears `Done_o`. `Start_i` sampled at this edge is accepted.
- Latency from start to `Done_o` is INPUT_WIDTH+1 cycles (28 for the default). Minimum start-to-start spacing is INPUT_WIDTH+2 cycles (29).
- `Busy_o` and `Done_o` are registered (state-decoded from registers); no combinational path from inputs to outputs.

## Structure
- Shared package/header `bcd_pkg`:
  - `BCD_DIGITS` = 8
  - `BCD_MAX` = 27'd99_999_999
  - FSM state encodings: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2
- Sub-module `bcd_digit_adjust`: 4-bit in, 4-bit out, output = in+3 when in ≥ 5, else in. It is the one natural sub-module, instantiated `BCD_DIGITS` times in a generate loop.
- Top holds the FSM, counter (width $clog2(INPUT_WIDTH)), operand, scratch and output registers.

## Test plan
- Reset, then `Binary_i`=0 with one `Start_i` pulse:
  - `Busy_o` high for 28 cycles, `Done_o` high exactly one cycle at edge 28.
  - `Data_o`=0x0000_0000, `Overflow_o`=0.
- `Binary_i`=12 345 678 → `Data_o`=0x1234_5678. `Binary_i`=99 999 999 → `Data_o`=0x9999_9999, `Overflow_o`=0.
- `Binary_i`=100 000 000, then separately 134 217 727 → `Data_o`=0x9999_9999, `Overflow_o`=1 in both cases.
- Convert 42 → `Data_o`=0x0000_0042. Then start 7, and while Busy pulse `Start_i` with `Binary_i`=555:
  - `Data_o` stays 0x0000_0042 until the single `Done_o`, then becomes 0x0000_0007.
  - No second `Done_o`.
- Assert `Reset` at edge 10 of a conversion of 87 654 321 → all outputs 0 on the next cycle. A fresh start of 305 then yields 0x0000_0305 after 28 cycles.
- Back-to-back: hold `Start_i`=1 continuously with `Binary_i` alternating 1/10 per conversion → `Done_o` pulses every 29 cycles. `Data_o` alternates 0x0000_0001 / 0x0000_0010.
